// File: rtl/count_direction_monitor.sv
// Passive monitor of an up/down counter bus: infers direction, lock, wraps and illegal steps.
// Optional wrap statistics counter enabled by defining COUNT_MON_WRAP_STATS_EN.
module count_direction_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 2
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Count,
  input  logic             clear,
  output logic             Dir,
  output logic             Locked,
  output logic             Fault,
  output logic             StepErr,
  output logic             WrapPulse,
  output logic [7:0]       WrapCount
);

  typedef enum logic [1:0] {ACQUIRE, SEARCH, LOCKED, FAULT} state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_STEPS);

  state_t           state, state_nx;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] delta;
  logic [3:0]       run, run_nx;
  logic             dir_nx, step_err_nx, wrap_nx;
  logic             step_up, step_dn, step_hold, step_bad;
  logic             wrap_seen;

  assign delta     = Count - prev;
  assign step_up   = (delta == WIDTH'(1));
  assign step_dn   = (delta == '1);
  assign step_hold = (delta == '0);
  assign step_bad  = !(step_up || step_dn || step_hold);
  // A legal step landing on 0 going up, or on all-ones going down, crossed the boundary.
  assign wrap_seen = (step_up && (Count == '0)) || (step_dn && (prev == '0));

  assign Locked = (state == LOCKED);
  assign Fault  = (state == FAULT);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latches are inferred.
    state_nx    = state;
    dir_nx      = Dir;
    run_nx      = run;
    step_err_nx = 1'b0;
    wrap_nx     = 1'b0;
    if (clear) begin
      state_nx = ACQUIRE;
      run_nx   = '0;
    end else begin
      unique case (state)
        ACQUIRE: state_nx = SEARCH;
        SEARCH: begin
          wrap_nx = wrap_seen;
          if (step_up || step_dn) begin
            if (step_up == Dir) begin
              run_nx = run + 4'd1;
            end else begin
              dir_nx = step_up;
              run_nx = 4'd1;
            end
            if (run_nx >= LOCK_RUN) state_nx = LOCKED;
          end else if (step_bad) begin
            run_nx      = '0;
            step_err_nx = 1'b1;
          end
        end
        LOCKED: begin
          wrap_nx = wrap_seen;
          if ((step_up && !Dir) || (step_dn && Dir)) begin
            dir_nx   = !Dir;
            run_nx   = 4'd1;
            state_nx = SEARCH;
          end else if (step_bad) begin
            step_err_nx = 1'b1;
            state_nx    = FAULT;
          end
        end
        FAULT: ;
        default: state_nx = ACQUIRE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous active-low.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state     <= ACQUIRE;
      prev      <= '0;
      run       <= '0;
      Dir       <= 1'b0;
      StepErr   <= 1'b0;
      WrapPulse <= 1'b0;
    end else begin
      state     <= state_nx;
      prev      <= Count;
      run       <= run_nx;
      Dir       <= dir_nx;
      StepErr   <= step_err_nx;
      WrapPulse <= wrap_nx;
    end
  end

`ifdef COUNT_MON_WRAP_STATS_EN
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      WrapCount <= '0;
    end else if (clear) begin
      WrapCount <= '0;
    end else if (wrap_nx && (WrapCount != 8'hFF)) begin
      WrapCount <= WrapCount + 8'd1;
    end
  end
`else
  assign WrapCount = '0;
`endif

endmodule

// File: tb/tb_count_direction_monitor.sv
// Directed, table-driven bench for count_direction_monitor (WIDTH=4, LOCK_STEPS=2).
module tb_count_direction_monitor;

  logic       Clk = 1'b0;
  logic       reset;
  logic [3:0] Count;
  logic       clear;
  logic       Dir, Locked, Fault, StepErr, WrapPulse;
  logic [7:0] WrapCount;

  int errors = 0;
  int checks = 0;

  count_direction_monitor #(.WIDTH(4), .LOCK_STEPS(2)) dut (
    .Clk(Clk), .reset(reset), .Count(Count), .clear(clear),
    .Dir(Dir), .Locked(Locked), .Fault(Fault), .StepErr(StepErr),
    .WrapPulse(WrapPulse), .WrapCount(WrapCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       clr;
    logic [3:0] cnt;
    logic [4:0] flags;  // {Dir, Locked, Fault, StepErr, WrapPulse}
    logic [7:0] wc;     // value with wrap statistics enabled
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic clr, input int cnt, input logic d, input logic l,
                              input logic f, input logic s, input logic w, input int wc);
    vec_t v;
    v.clr   = clr;
    v.cnt   = 4'(cnt);
    v.flags = {d, l, f, s, w};
    v.wc    = 8'(wc);
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] exp_wc(input logic [7:0] wc);
`ifdef COUNT_MON_WRAP_STATS_EN
    return wc;
`else
    return (wc === 8'hxx) ? 8'h00 : 8'h00;
`endif
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {dir,lock,fault,err,wrap,wc}=%b_%h expected %b_%h",
               name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  function automatic logic [12:0] outs();
    return {Dir, Locked, Fault, StepErr, WrapPulse, WrapCount};
  endfunction

  initial begin
    int pulses;
    logic [3:0] c;

    //   clr cnt d l f s w wc
    add(0,  0, 0,0,0,0,0, 0);  // acquire edge
    add(0,  1, 1,0,0,0,0, 0);  // reversal from reset Dir=0
    add(0,  2, 1,1,0,0,0, 0);  // lock on second step
    add(0,  3, 1,1,0,0,0, 0);
    add(1, 12, 1,0,0,0,0, 0);  // clear with illegal jump: no StepErr, Dir kept
    add(0, 13, 1,0,0,0,0, 0);  // acquire edge
    add(0, 14, 1,0,0,0,0, 0);
    add(0, 15, 1,1,0,0,0, 0);
    add(0,  0, 1,1,0,0,1, 1);  // up wrap
    add(0,  1, 1,1,0,0,0, 1);
    add(0,  2, 1,1,0,0,0, 1);
    add(0,  3, 1,1,0,0,0, 1);
    add(0,  4, 1,1,0,0,0, 1);
    add(0,  5, 1,1,0,0,0, 1);
    add(0,  4, 0,0,0,0,0, 1);  // reversal while locked
    add(0,  3, 0,1,0,0,0, 1);  // relock down
    add(0,  2, 0,1,0,0,0, 1);
    add(0,  1, 0,1,0,0,0, 1);
    add(0,  0, 0,1,0,0,0, 1);
    add(0, 15, 0,1,0,0,1, 2);  // down wrap
    add(0,  0, 1,0,0,0,1, 3);  // reversal at wrap value, counted
    add(0, 15, 0,0,0,0,1, 4);  // reversal in SEARCH at wrap value, counted
    add(0, 14, 0,1,0,0,0, 4);
    add(0, 15, 1,0,0,0,0, 4);
    add(0,  9, 1,0,0,1,0, 4);  // illegal before lock: pulse only
    add(0, 10, 1,0,0,0,0, 4);
    add(0, 11, 1,1,0,0,0, 4);
    add(0, 11, 1,1,0,0,0, 4);  // hold
    add(0,  4, 1,0,1,1,0, 4);  // illegal while locked: fault
    add(0,  5, 1,0,1,0,0, 4);  // frozen
    add(0,  6, 1,0,1,0,0, 4);
    add(0, 15, 1,0,1,0,0, 4);  // illegal ignored in fault
    add(0,  0, 1,0,1,0,0, 4);  // wrap ignored in fault
    add(1,  5, 1,0,0,0,0, 0);  // clear wins over illegal step
    add(0,  1, 1,0,0,0,0, 0);
    add(0,  2, 1,0,0,0,0, 0);
    add(0,  3, 1,1,0,0,0, 0);
    add(0,  2, 0,0,0,0,0, 0);
    add(0,  1, 0,1,0,0,0, 0);
    add(0,  0, 0,1,0,0,0, 0);
    add(0, 15, 0,1,0,0,1, 1);
    add(0,  0, 1,0,0,0,1, 2);
    add(1, 15, 1,0,0,0,0, 0);  // clear with a down wrap: no pulse, no count
    add(0, 14, 1,0,0,0,0, 0);
    add(0, 15, 1,0,0,0,0, 0);
    add(0,  0, 1,1,0,0,1, 1);
    for (int i = 1; i <= 7; i++) add(0, i, 1,1,0,0,0, 1);

    reset = 1'b0;
    Count = 4'd0;
    clear = 1'b0;
    #12;
    check("reset_state", outs(), 13'b0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      Count = vecs[i].cnt;
      clear = vecs[i].clr;
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d", i), outs(), {vecs[i].flags, exp_wc(vecs[i].wc)});
    end
    clear = 1'b0;

    // Hold at 7 while locked up.
    for (int i = 0; i < 10; i++) begin
      Count = 4'd7;
      @(posedge Clk);
      #1;
      check($sformatf("hold%0d", i), outs(), {5'b11000, exp_wc(8'd1)});
    end

    // Count up through 260 wraps: WrapCount saturates at 255.
    pulses = 0;
    c = 4'd7;
    for (int n = 1; n <= 4160; n++) begin
      c = c + 4'd1;
      Count = c;
      @(posedge Clk);
      #1;
      if (WrapPulse) pulses++;
    end
    checks++;
    if (pulses != 260) begin
      errors++;
      $display("FAIL wrap_pulses: got %0d expected 260", pulses);
    end
    check("wrap_saturate", outs(), {5'b11000, exp_wc(8'd255)});

    // Asynchronous reset mid-cycle.
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", outs(), 13'b0);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_direction_monitor.md
# count_direction_monitor

Passive monitor on the up/down counter's output bus. It samples `Count` every clock and classifies each step between consecutive samples as up, down, hold or illegal. From that it infers the counter's direction, reports lock once the direction is stable, and flags wrap-arounds and illegal jumps. It sits beside the counter in system benches and on-chip as a sanity checker, and is the reader of the bus the counter drives.

## Interface
- `WIDTH`, 4: width of the monitored `Count` bus.
- `LOCK_STEPS`, 2: consecutive same-direction steps needed to assert `Locked`; legal range 1..15.
- `Clk` input 1: clock, rising-edge active.
- `reset` input 1: asynchronous, active-low reset.
- `Count` input WIDTH: counter value under observation, sampled on rising `Clk`.
- `clear` input 1: synchronous, active-high; clears the fault state and statistics.
- `Dir` output 1: inferred direction; 1 = up, 0 = down.
- `Locked` output 1: direction is stable for at least `LOCK_STEPS` steps.
- `Fault` output 1: sticky; set when an illegal step is seen.
- `StepErr` output 1: one-cycle pulse on each illegal step.
- `WrapPulse` output 1: one-cycle pulse on each legal wrap.
- `WrapCount` output 8: saturating count of wraps.

## Operation
- `prev` register holds the previous `Count` sample.
- `delta = (Count - prev) mod 2^WIDTH`.
- Step classification:
  - `delta == 1`: up.
  - `delta == 2^WIDTH-1`: down.
  - `delta == 0`: hold.
  - anything else: illegal.
- Wrap definitions:
  - Up wrap: up step where `prev == 2^WIDTH-1` and `Count == 0`.
  - Down wrap: down step where `prev == 0` and `Count == 2^WIDTH-1`.
- FSM states: ACQUIRE, SEARCH, LOCKED, FAULT.
- ACQUIRE (reset state):
  - Load `prev` only; no classification.
  - Go to SEARCH on the next edge.
- SEARCH:
  - Up/down step matching `Dir`: increment the 4-bit run counter.
  - Up/down step opposite to `Dir`: set `Dir` to the new direction, run = 1.
  - Hold: no change.
  - Illegal step: run = 0, pulse `StepErr`, stay in SEARCH (no fault before lock).
  - When run reaches `LOCK_STEPS`: go to LOCKED, assert `Locked`.
- LOCKED:
  - Same-direction step or hold: stay.
  - Opposite step is a legal reversal: flip `Dir`, deassert `Locked`, run = 1, go to SEARCH.
  - Illegal step: pulse `StepErr`, set `Fault`, deassert `Locked`, go to FAULT.
- FAULT:
  - Ignore all steps except that `prev` keeps tracking `Count`.
  - No wraps counted.
  - `clear` goes to ACQUIRE.
- `clear` in any state goes to ACQUIRE and zeroes `Fault`, `Locked`, run and `WrapCount`. `Dir` is retained.
- Wraps are recognised in SEARCH and LOCKED only.
- `WrapCount` increments per wrap and saturates at 255.

## Timing
- Reset values: state ACQUIRE, `Dir`=0, `Locked`=0, `Fault`=0, `StepErr`=0, `WrapPulse`=0, `WrapCount`=0, `prev`=0, run=0.
- Reset assertion clears all state immediately, without waiting for `Clk`.
- A step between samples at edges n-1 and n updates all outputs at edge n.
- Latency: 0 cycles beyond the second sample.
- `StepErr` and `WrapPulse` are high for exactly one cycle per event.
- `Locked` first rises at the edge that samples step number `LOCK_STEPS` after ACQUIRE.
  - Example with default `LOCK_STEPS=2`: reset release, ACQUIRE edge, then `Locked` rises on the third sampling edge.
- Simultaneous events:
  - `clear` together with an illegal step: `clear` wins, no `StepErr`.
  - `clear` together with a wrap: no increment; `WrapCount`=0.
- A direction reversal exactly at a wrap value (e.g. 15→0 then 0→15) is a wrap in each direction. Both are counted.

## Configuration
- Macro: `COUNT_MON_WRAP_STATS_EN`.
- Defined: `WrapCount` register present and behaves as specified.
- Undefined:
  - `WrapCount` is tied to constant 0 and no counter register is built.
  - `WrapPulse` and all other behaviour are unchanged.

## Test plan
All scenarios use WIDTH=4 and LOCK_STEPS=2.
- Release reset, drive `Count` 0,1,2,3 on successive edges → `Dir`=1; `Locked`=1 from the edge sampling 2; `Fault`=0.
- Locked up, drive 14,15,0,1 → single-cycle `WrapPulse` at the edge sampling 0; `WrapCount`=1; `Locked` stays 1.
- Locked up at 5, drive 4,3 → at 4: `Locked`=0, `Dir`=0; at 3: `Locked`=1.
- Locked at 4, drive 9 → `StepErr` pulse, `Fault`=1, `Locked`=0. Legal steps afterwards leave outputs frozen. `clear` for one cycle → `Fault`=0, relock after 2 steps.
- Hold `Count`=7 for 10 cycles while locked → no output change. Pull `reset` low mid-cycle → all outputs 0 before the next edge.
- Build without `COUNT_MON_WRAP_STATS_EN`, run 3 up wraps → `WrapPulse` pulses 3 times, `WrapCount` stays 0.
